// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_pkg
//  Purpose  : Shared AHB-Lite encodings and the peripheral bridge state type.
//  Revision : 1.0 - initial release
// ============================================================================
package ahb_pkg;

    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] c_HSIZE_BYTE = 3'd0;
    localparam logic [2:0] c_HSIZE_HALF = 3'd1;
    localparam logic [2:0] c_HSIZE_WORD = 3'd2;

    localparam logic c_HRESP_OKAY  = 1'b0;
    localparam logic c_HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_RD       = 3'd2,
        ST_RD_STALL = 3'd3,
        ST_ERR1     = 3'd4,
        ST_ERR2     = 3'd5
    } bridgeState_e;

endpackage
`default_nettype wire

// File: rtl/ahb_periph_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_periph_bridge_if
//  Purpose  : AHB-Lite slave-side bus bundle for the peripheral bridge.
//  Revision : 1.0 - initial release
// ============================================================================
interface ahb_periph_bridge_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

endinterface
`default_nettype wire

// File: rtl/ahb_size_decode.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_size_decode
//  Purpose  : Maps HSIZE and HADDR[1:0] to byte write strobes plus a
//             misaligned-access flag. Purely combinational.
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_size_decode
    import ahb_pkg::*;
(
    input  wire  [2:0] i_hsize,
    input  wire  [1:0] i_addrLo,
    output logic [3:0] o_strobe,
    output logic       o_misaligned
);

    // Oversized and misaligned halves/words still produce an aligned-down
    // strobe so the non-error build can use it directly.
    always_comb begin
        o_strobe     = 4'b1111;
        o_misaligned = 1'b0;
        case (i_hsize)
            c_HSIZE_BYTE: o_strobe = 4'b0001 << i_addrLo;
            c_HSIZE_HALF: begin
                o_strobe     = i_addrLo[1] ? 4'b1100 : 4'b0011;
                o_misaligned = i_addrLo[0];
            end
            c_HSIZE_WORD: o_misaligned = (i_addrLo != 2'b00);
            default:      o_misaligned = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ahb_periph_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_periph_bridge
//  Purpose  : AHB-Lite slave to word-indexed peripheral port bridge with a
//             read-after-write stall. Define AHB_BRIDGE_ERR_EN to enable the
//             two-cycle ERROR response for misaligned/oversized accesses.
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_periph_bridge
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  wire                clk,
    input  wire                rstn,
    ahb_periph_bridge_if.slave bus,
    output logic [ADDR_W-1:0]  addrIn,
    output logic [ADDR_W-1:0]  addrOut,
    output logic [3:0]         sizeDecode,
    output logic [31:0]        dataIn,
    input  wire  [31:0]        dataOut
);

    localparam logic [2:0] c_IDLE     = ST_IDLE;
    localparam logic [2:0] c_WR       = ST_WR;
    localparam logic [2:0] c_RD       = ST_RD;
    localparam logic [2:0] c_RD_STALL = ST_RD_STALL;
`ifdef AHB_BRIDGE_ERR_EN
    localparam logic [2:0] c_ERR1     = ST_ERR1;
    localparam logic [2:0] c_ERR2     = ST_ERR2;
`endif

    logic [2:0]        r_state;
    logic [2:0]        w_nextState;
    logic [ADDR_W-1:0] r_wrIndex;
    logic [ADDR_W-1:0] r_rdIndex;
    logic [3:0]        r_strobe;

    logic [ADDR_W-1:0] w_index;
    logic [3:0]        w_strobe;
    logic              w_misaligned;
    logic              w_error;
    logic              w_readyOut;
    logic              w_validPhase;
    logic              w_accept;
    logic              w_readAccept;
    logic              w_hazard;
    logic              w_unusedAddr;

    ahb_size_decode u_sizeDecode (
        .i_hsize      (bus.HSIZE),
        .i_addrLo     (bus.HADDR[1:0]),
        .o_strobe     (w_strobe),
        .o_misaligned (w_misaligned)
    );

    assign w_index      = bus.HADDR[ADDR_W+1:2];
    assign w_unusedAddr = ^bus.HADDR[31:ADDR_W+2];
    assign w_validPhase = bus.HSEL & bus.HREADY &
                          ((bus.HTRANS == c_HTRANS_NONSEQ) || (bus.HTRANS == c_HTRANS_SEQ));
    assign w_accept     = w_validPhase & w_readyOut;
    // rstn gates the combinational read path so addrOut holds 0 in reset
    assign w_readAccept = w_accept & ~bus.HWRITE & rstn;
    assign w_hazard     = (r_state == c_WR) & ~bus.HWRITE & (w_index == r_wrIndex);

`ifdef AHB_BRIDGE_ERR_EN
    assign w_error    = w_misaligned;
    assign w_readyOut = (r_state != c_RD_STALL) && (r_state != c_ERR1);
    assign bus.HRESP  = ((r_state == c_ERR1) || (r_state == c_ERR2)) ? c_HRESP_ERROR
                                                                      : c_HRESP_OKAY;
`else
    logic w_unusedMisaligned;
    assign w_unusedMisaligned = w_misaligned;
    assign w_error    = 1'b0;
    assign w_readyOut = (r_state != c_RD_STALL);
    assign bus.HRESP  = c_HRESP_OKAY;
`endif

    always_comb begin
        w_nextState = c_IDLE;
        case (r_state)
            c_RD_STALL: w_nextState = c_RD;
`ifdef AHB_BRIDGE_ERR_EN
            c_ERR1:     w_nextState = c_ERR2;
`endif
            default: begin
                if (!w_accept)
                    w_nextState = c_IDLE;
`ifdef AHB_BRIDGE_ERR_EN
                else if (w_error)
                    w_nextState = c_ERR1;
`endif
                else if (bus.HWRITE)
                    w_nextState = c_WR;
                else if (w_hazard)
                    w_nextState = c_RD_STALL;
                else
                    w_nextState = c_RD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= c_IDLE;
            r_wrIndex <= '0;
            r_rdIndex <= '0;
            r_strobe  <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_accept && !bus.HWRITE)
                r_rdIndex <= w_index;
            // Erroring writes leave the previous write phase info untouched
            if (w_accept && bus.HWRITE && !w_error) begin
                r_wrIndex <= w_index;
                r_strobe  <= w_strobe;
            end
        end
    end

    assign bus.HREADYOUT = w_readyOut;
    assign bus.HRDATA    = (r_state == c_RD) ? dataOut : 32'h0;
    assign sizeDecode    = (r_state == c_WR) ? r_strobe : 4'b0000;
    assign dataIn        = (r_state == c_WR) ? bus.HWDATA : 32'h0;
    assign addrIn        = r_wrIndex;
    assign addrOut       = w_readAccept ? w_index : r_rdIndex;

endmodule
`default_nettype wire

// File: tb/tb_ahb_periph_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_periph_bridge
//  Purpose  : Self-checking bench for ahb_periph_bridge with a register-file
//             peripheral and a transaction-level reference memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_periph_bridge;
    import ahb_pkg::*;

    localparam int ADDR_W = 8;
    localparam logic [1:0] K_IDLE = 2'd0;
    localparam logic [1:0] K_WR   = 2'd1;
    localparam logic [1:0] K_RD   = 2'd2;
    localparam logic [1:0] K_ERR  = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  idx;
        logic [3:0]  strb;
        logic [31:0] data;
        logic        haz;
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        wr;
    } op_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ahb_periph_bridge_if bus ();
    assign bus.HREADY = bus.HREADYOUT;

    logic [ADDR_W-1:0] addrIn, addrOut;
    logic [3:0]        sizeDecode;
    logic [31:0]       dataIn, dataOut;

    ahb_periph_bridge #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .addrIn     (addrIn),
        .addrOut    (addrOut),
        .sizeDecode (sizeDecode),
        .dataIn     (dataIn),
        .dataOut    (dataOut)
    );

    // Peripheral register file: byte-strobed write, registered read
    logic [31:0] periphMem [0:255];
    logic [31:0] refMem    [0:255];
    logic        preEn;
    logic [7:0]  preIdx;
    logic [31:0] preVal;

    always @(posedge clk) begin : periphModel
        logic [31:0] merged;
        merged = periphMem[addrIn];
        for (int b = 0; b < 4; b++)
            if (sizeDecode[b]) merged[8*b +: 8] = dataIn[8*b +: 8];
        if (preEn)
            periphMem[preIdx] <= preVal;
        else if (|sizeDecode)
            periphMem[addrIn] <= merged;
        dataOut <= periphMem[addrOut];
    end

    int nCompared;
    int nMismatched;

    task automatic drive_addr(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                              input logic [2:0] size, input logic wr);
        bus.HSEL = sel; bus.HTRANS = trans; bus.HADDR = addr; bus.HSIZE = size; bus.HWRITE = wr;
    endtask

    task automatic drive_idle();
        drive_addr(1'b0, c_HTRANS_IDLE, 32'h0, c_HSIZE_WORD, 1'b0);
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        @(posedge clk); #1;
        preEn = 1'b1; preIdx = idx; preVal = val;
        @(posedge clk); #1;
        preEn = 1'b0;
        refMem[idx] = val;
    endtask

    function automatic logic [3:0] spec_strobe(input logic [2:0] size, input logic [1:0] lo);
        if (size == 3'd0) return 4'(1 << lo);
        if (size == 3'd1) return lo[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic op_t idle_op();
        op_t o;
        o = '0;
        o.kind = K_IDLE;
        o.size = 3'd2;
        return o;
    endfunction

    function automatic op_t rand_op(input bit allowMis);
        op_t o;
        logic [1:0] lo;
        logic mis;
        int r;
        o = '0;
        r = $urandom_range(0, 9);
        o.size = allowMis ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 2));
        lo = 2'($urandom);
        if (!allowMis && o.size == 3'd1) lo[0] = 1'b0;
        if (!allowMis && o.size == 3'd2) lo = 2'b00;
        o.idx  = 8'($urandom_range(0, 7));
        o.addr = {22'($urandom), o.idx, lo};
        o.data = $urandom;
        o.strb = spec_strobe(o.size, lo);
        mis = (o.size == 3'd1 && lo[0]) || (o.size == 3'd2 && lo != 2'b00) || (o.size > 3'd2);
        if (r < 2) begin
            o.kind  = K_IDLE;
            o.sel   = (r == 1);
            o.trans = o.sel ? 2'($urandom_range(0, 1)) : 2'($urandom);
            o.wr    = 1'($urandom);
        end else begin
            o.sel   = 1'b1;
            o.trans = $urandom_range(0, 1) ? c_HTRANS_NONSEQ : c_HTRANS_SEQ;
            o.wr    = (r < 6);
            o.kind  = o.wr ? K_WR : K_RD;
`ifdef AHB_BRIDGE_ERR_EN
            if (mis) o.kind = K_ERR;
`else
            if (mis) o.kind = o.kind;
`endif
        end
        return o;
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        drive_idle();
        bus.HWDATA = 32'h0;
        for (int i = 0; i < 8; i++) preload(8'(i), 32'hA5A5_0000 | i);
        drive_addr(1'b1, c_HTRANS_NONSEQ, 32'h1C, c_HSIZE_WORD, 1'b0);
        bus.HWDATA = 32'hFFFF_FFFF;
        #1;
        nCompared++; if (bus.HREADYOUT !== 1'b1) begin nMismatched++; $display("FAIL reset HREADYOUT got %b want 1", bus.HREADYOUT); end
        nCompared++; if (bus.HRESP !== 1'b0) begin nMismatched++; $display("FAIL reset HRESP got %b want 0", bus.HRESP); end
        nCompared++; if (bus.HRDATA !== 32'h0) begin nMismatched++; $display("FAIL reset HRDATA got %h want 0", bus.HRDATA); end
        nCompared++; if (sizeDecode !== 4'h0) begin nMismatched++; $display("FAIL reset sizeDecode got %h want 0", sizeDecode); end
        nCompared++; if (addrIn !== 8'h0) begin nMismatched++; $display("FAIL reset addrIn got %h want 0", addrIn); end
        nCompared++; if (addrOut !== 8'h0) begin nMismatched++; $display("FAIL reset addrOut got %h want 0", addrOut); end
        nCompared++; if (dataIn !== 32'h0) begin nMismatched++; $display("FAIL reset dataIn got %h want 0", dataIn); end
        drive_idle();
        @(negedge clk); rstn = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_word_write();
        @(posedge clk); #1; drive_addr(1'b1, c_HTRANS_NONSEQ, 32'h04, c_HSIZE_WORD, 1'b1);
        @(posedge clk); #1; drive_idle(); bus.HWDATA = 32'h1234_5678;
        @(negedge clk);
        nCompared++; if (addrIn !== 8'd1) begin nMismatched++; $display("FAIL word_write addrIn got %h want 01", addrIn); end
        nCompared++; if (sizeDecode !== 4'b1111) begin nMismatched++; $display("FAIL word_write sizeDecode got %b want 1111", sizeDecode); end
        nCompared++; if (dataIn !== 32'h1234_5678) begin nMismatched++; $display("FAIL word_write dataIn got %h want 12345678", dataIn); end
        nCompared++; if (bus.HREADYOUT !== 1'b1) begin nMismatched++; $display("FAIL word_write HREADYOUT got %b want 1", bus.HREADYOUT); end
        refMem[1] = 32'h1234_5678;
    endtask

    task automatic test_byte_write();
        @(posedge clk); #1; drive_addr(1'b1, c_HTRANS_NONSEQ, 32'h07, c_HSIZE_BYTE, 1'b1);
        @(posedge clk); #1; drive_idle(); bus.HWDATA = {8'hCC, 24'($urandom)};
        @(negedge clk);
        nCompared++; if (sizeDecode !== 4'b1000) begin nMismatched++; $display("FAIL byte_write sizeDecode got %b want 1000", sizeDecode); end
        refMem[1][31:24] = 8'hCC;
        @(posedge clk); #1; drive_addr(1'b1, c_HTRANS_NONSEQ, 32'h04, c_HSIZE_WORD, 1'b0);
        @(posedge clk); #1; drive_idle();
        @(negedge clk);
        nCompared++; if (bus.HRDATA !== 32'hCC34_5678) begin nMismatched++; $display("FAIL byte_readback HRDATA got %h want cc345678", bus.HRDATA); end
    endtask

    task automatic test_timer_read();
        preload(8'd0, 32'd5);
        @(posedge clk); #1; drive_addr(1'b1, c_HTRANS_NONSEQ, 32'h00, c_HSIZE_WORD, 1'b0);
        @(posedge clk); #1; drive_idle();
        @(negedge clk);
        nCompared++; if (bus.HREADYOUT !== 1'b1) begin nMismatched++; $display("FAIL timer_read HREADYOUT got %b want 1", bus.HREADYOUT); end
        nCompared++; if (bus.HRDATA !== 32'd5) begin nMismatched++; $display("FAIL timer_read HRDATA got %h want 5", bus.HRDATA); end
    endtask

    task automatic test_hazard();
        // Same word: one stall cycle, then the freshly written value
        @(posedge clk); #1; drive_addr(1'b1, c_HTRANS_NONSEQ, 32'h08, c_HSIZE_WORD, 1'b1);
        @(posedge clk); #1; drive_addr(1'b1, c_HTRANS_NONSEQ, 32'h08, c_HSIZE_WORD, 1'b0); bus.HWDATA = 32'hAA;
        @(negedge clk);
        nCompared++; if (addrOut !== 8'd2) begin nMismatched++; $display("FAIL hazard addrOut_phase got %h want 02", addrOut); end
        refMem[2] = 32'hAA;
        @(posedge clk); #1; drive_idle();
        @(negedge clk);
        nCompared++; if (bus.HREADYOUT !== 1'b0) begin nMismatched++; $display("FAIL hazard stall HREADYOUT got %b want 0", bus.HREADYOUT); end
        nCompared++; if (addrOut !== 8'd2) begin nMismatched++; $display("FAIL hazard addrOut_stall got %h want 02", addrOut); end
        @(posedge clk); #1;
        @(negedge clk);
        nCompared++; if (bus.HREADYOUT !== 1'b1) begin nMismatched++; $display("FAIL hazard done HREADYOUT got %b want 1", bus.HREADYOUT); end
        nCompared++; if (bus.HRDATA !== 32'hAA) begin nMismatched++; $display("FAIL hazard HRDATA got %h want aa", bus.HRDATA); end
        // Different word: no stall
        @(posedge clk); #1; drive_addr(1'b1, c_HTRANS_NONSEQ, 32'h08, c_HSIZE_WORD, 1'b1);
        @(posedge clk); #1; drive_addr(1'b1, c_HTRANS_NONSEQ, 32'h0C, c_HSIZE_WORD, 1'b0); bus.HWDATA = 32'hAA;
        @(posedge clk); #1; drive_idle();
        @(negedge clk);
        nCompared++; if (bus.HREADYOUT !== 1'b1) begin nMismatched++; $display("FAIL nohazard HREADYOUT got %b want 1", bus.HREADYOUT); end
        nCompared++; if (bus.HRDATA !== refMem[3]) begin nMismatched++; $display("FAIL nohazard HRDATA got %h want %h", bus.HRDATA, refMem[3]); end
    endtask

    task automatic test_misaligned();
        @(posedge clk); #1; drive_addr(1'b1, c_HTRANS_NONSEQ, 32'h02, c_HSIZE_WORD, 1'b1);
        @(posedge clk); #1; drive_addr(1'b1, c_HTRANS_NONSEQ, 32'h00, c_HSIZE_WORD, 1'b0); bus.HWDATA = 32'hDEAD_BEEF;
        @(negedge clk);
`ifdef AHB_BRIDGE_ERR_EN
        nCompared++; if (bus.HREADYOUT !== 1'b0 || bus.HRESP !== 1'b1 || sizeDecode !== 4'h0) begin nMismatched++; $display("FAIL err1 rdy/resp/strb got %b/%b/%h want 0/1/0", bus.HREADYOUT, bus.HRESP, sizeDecode); end
        @(posedge clk); #1;
        @(negedge clk);
        nCompared++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b1 || sizeDecode !== 4'h0) begin nMismatched++; $display("FAIL err2 rdy/resp/strb got %b/%b/%h want 1/1/0", bus.HREADYOUT, bus.HRESP, sizeDecode); end
`else
        nCompared++; if (sizeDecode !== 4'b1111 || addrIn !== 8'd0 || dataIn !== 32'hDEAD_BEEF) begin nMismatched++; $display("FAIL align_down strb/addrIn/dataIn got %b/%h/%h want 1111/00/deadbeef", sizeDecode, addrIn, dataIn); end
        refMem[0] = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        @(negedge clk);
        nCompared++; if (bus.HREADYOUT !== 1'b0 || bus.HRESP !== 1'b0) begin nMismatched++; $display("FAIL align_down stall rdy/resp got %b/%b want 0/0", bus.HREADYOUT, bus.HRESP); end
`endif
        @(posedge clk); #1; drive_idle();
        @(negedge clk);
        nCompared++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin nMismatched++; $display("FAIL misaligned_after rdy/resp got %b/%b want 1/0", bus.HREADYOUT, bus.HRESP); end
        nCompared++; if (bus.HRDATA !== refMem[0]) begin nMismatched++; $display("FAIL misaligned_after HRDATA got %h want %h", bus.HRDATA, refMem[0]); end
    endtask

    task automatic test_reset_midwrite();
        @(posedge clk); #1; drive_addr(1'b1, c_HTRANS_NONSEQ, 32'h0C, c_HSIZE_WORD, 1'b1);
        @(posedge clk); #1; drive_idle(); bus.HWDATA = 32'h5555_AAAA;
        #2;
        nCompared++; if (sizeDecode !== 4'b1111) begin nMismatched++; $display("FAIL midreset pre sizeDecode got %b want 1111", sizeDecode); end
        rstn = 1'b0;
        #1;
        nCompared++; if (sizeDecode !== 4'h0 || dataIn !== 32'h0 || addrIn !== 8'h0) begin nMismatched++; $display("FAIL midreset strb/dataIn/addrIn got %h/%h/%h want 0/0/0", sizeDecode, dataIn, addrIn); end
        nCompared++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0 || bus.HRDATA !== 32'h0) begin nMismatched++; $display("FAIL midreset rdy/resp/rdata got %b/%b/%h want 1/0/0", bus.HREADYOUT, bus.HRESP, bus.HRDATA); end
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1; drive_addr(1'b1, c_HTRANS_NONSEQ, 32'h0C, c_HSIZE_WORD, 1'b0);
        @(posedge clk); #1; drive_idle();
        @(negedge clk);
        nCompared++; if (bus.HRDATA !== refMem[3]) begin nMismatched++; $display("FAIL midreset no_partial HRDATA got %h want %h", bus.HRDATA, refMem[3]); end
        @(posedge clk); #1; drive_addr(1'b1, c_HTRANS_NONSEQ, 32'h0E, c_HSIZE_HALF, 1'b1);
        @(posedge clk); #1; drive_idle(); bus.HWDATA = 32'h7777_0000;
        @(negedge clk);
        nCompared++; if (sizeDecode !== 4'b1100) begin nMismatched++; $display("FAIL postreset sizeDecode got %b want 1100", sizeDecode); end
        refMem[3][31:16] = 16'h7777;
        @(posedge clk); #1; drive_addr(1'b1, c_HTRANS_NONSEQ, 32'h0C, c_HSIZE_WORD, 1'b0);
        @(posedge clk); #1; drive_idle();
        @(negedge clk);
        nCompared++; if (bus.HRDATA !== refMem[3]) begin nMismatched++; $display("FAIL postreset HRDATA got %h want %h", bus.HRDATA, refMem[3]); end
    endtask

    task automatic test_random(input int nOps, input bit allowMis);
        op_t ap, dp;
        int dpCyc;
        bit expRdy, nextHaz;
        logic [31:0] expData;
        ap = idle_op(); dp = idle_op(); dpCyc = 0; expRdy = 1'b1;
        for (int c = 0; c < nOps + 4; c++) begin
            @(posedge clk); #1;
            if (expRdy) begin
                nextHaz = (ap.kind == K_RD) && (dp.kind == K_WR) && (ap.idx == dp.idx);
                dp = ap; dp.haz = nextHaz; dpCyc = 0;
                ap = (c < nOps) ? rand_op(allowMis) : idle_op();
            end else begin
                dpCyc++;
            end
            drive_addr(ap.sel, ap.trans, ap.addr, ap.size, ap.wr);
            bus.HWDATA = (dp.kind == K_WR) ? dp.data : $urandom;
            @(negedge clk);
            case (dp.kind)
                K_WR: begin
                    expRdy = 1'b1;
                    nCompared++; if (sizeDecode !== dp.strb || addrIn !== dp.idx || dataIn !== dp.data) begin nMismatched++; $display("FAIL rand_wr c=%0d strb/addrIn/dataIn got %b/%h/%h want %b/%h/%h", c, sizeDecode, addrIn, dataIn, dp.strb, dp.idx, dp.data); end
                    for (int b = 0; b < 4; b++)
                        if (dp.strb[b]) refMem[dp.idx][8*b +: 8] = dp.data[8*b +: 8];
                end
                K_RD: begin
                    expRdy  = !(dp.haz && dpCyc == 0);
                    expData = expRdy ? refMem[dp.idx] : 32'h0;
                    nCompared++; if (bus.HRDATA !== expData) begin nMismatched++; $display("FAIL rand_rd c=%0d HRDATA got %h want %h", c, bus.HRDATA, expData); end
                end
                K_ERR: begin
                    expRdy = (dpCyc != 0);
                    nCompared++; if (sizeDecode !== 4'h0) begin nMismatched++; $display("FAIL rand_err c=%0d sizeDecode got %h want 0", c, sizeDecode); end
                end
                default: begin
                    expRdy = 1'b1;
                    nCompared++; if (sizeDecode !== 4'h0 || bus.HRDATA !== 32'h0) begin nMismatched++; $display("FAIL rand_idle c=%0d strb/rdata got %h/%h want 0/0", c, sizeDecode, bus.HRDATA); end
                end
            endcase
            nCompared++; if (bus.HREADYOUT !== expRdy || bus.HRESP !== (dp.kind == K_ERR)) begin nMismatched++; $display("FAIL rand_hs c=%0d rdy/resp got %b/%b want %b/%b", c, bus.HREADYOUT, bus.HRESP, expRdy, (dp.kind == K_ERR)); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        nCompared = 0;
        nMismatched = 0;
        preEn = 1'b0; preIdx = 8'h0; preVal = 32'h0;
        test_reset();
        test_word_write();
        test_byte_write();
        test_timer_read();
        test_hazard();
        test_misaligned();
        test_reset_midwrite();
        test_random(400, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
